fpu_exce_resolver: RTL
======================

# fpu_exce_resolver

Back-end stage of the 8-bit FPU exception path: consumes the per-operation exception verdict (`OP_IS_EXCEPTION`, `FP_EXCE`) alongside the datapath result and emits the final architectural result. Special values replace the datapath result when an exception is flagged. The stage also accumulates sticky status flags, a saturating exception counter and a maskable interrupt. It sits between the arithmetic core and the FPU writeback, behind a one-deep registered valid/ready stage.

## Interface
- `LOG_DEPTH`, 4: exception log entries (power of two, ≥2); only used with the log enabled.
- `CLK` input 1: single clock, rising edge.
- `RST_N` input 1: asynchronous, active-low reset.
- `IN_VALID` input 1: upstream operation present.
- `IN_READY` output 1: stage can accept.
- `FP_OPERATION` input 2: `_ADDITION`/`_SUBTRACTION`/`_MULTIPLICATION`/`_DIVISION`.
- `OP_A`, `OP_B` input 8: operands (1 sign, 4 exponent, 3 mantissa).
- `ARITH_RESULT` input 8: datapath result.
- `OP_IS_EXCEPTION` input 1: exception verdict.
- `FP_EXCE` input 3: exception code.
- `RES_VALID` output 1 / `RES_READY` input 1: result handshake.
- `FP_RESULT` output 8: final result.
- `RES_EXCE` output 3: code travelling with the result.
- `STATUS` output 3: sticky flags, bit0 NV (NaN operand), bit1 INV (undefined inf op), bit2 DZ.
- `FLAG_CLR` input 1: clears `STATUS`, `EXCE_CNT`, `LOG_OVF`.
- `IRQ_MASK` input 3: per-flag interrupt enable.
- `IRQ` output 1: registered `|(STATUS & IRQ_MASK)`.
- `EXCE_CNT` output 8: saturating count of excepting operations.
- `LOG_VALID` output 1, `LOG_DATA` output 21 {op[20:19], exce[18:16], A[15:8], B[7:0]}, `LOG_POP` input 1, `LOG_OVF` output 1: exception log.

## Operation
- Transfer in: `IN_VALID && IN_READY`. Transfer out: `RES_VALID && RES_READY`.
- `IN_READY = !RES_VALID || RES_READY` (combinational, no skid buffer).
- Substitution on accept:
  - `OP_IS_EXCEPTION=0` → `ARITH_RESULT`.
  - `_qNAN_EXCE` → `_QNAN` (8'h7F).
  - `_INF_EXCE` → `_QNAN`.
  - `_ZERO_DIV_EXCE` → `_QNAN` if `OP_A` is ±0, otherwise signed inf: `{A[7]^B[7], 7'h78}`.
- `RES_EXCE` = `FP_EXCE` when excepting, otherwise `_NO_EXCE`.
- Flag update per accepted excepting transfer: qNaN sets NV, INF sets INV, ZERO_DIV sets DZ (0/0 also sets INV).
- `EXCE_CNT` increments and holds at 8'hFF.
- `FLAG_CLR` coincident with a setting transfer: the set wins; the counter loads 1.
- Undefined `FP_EXCE` code with `OP_IS_EXCEPTION=1`: output `_QNAN`, set INV.

## Timing
- Latency is 1 cycle, accept to `RES_VALID`. Throughput is 1 per cycle while `RES_READY=1`.
- `FP_RESULT`/`RES_EXCE` stable while `RES_VALID && !RES_READY`.
- `STATUS`, `EXCE_CNT` update the cycle after accept. `IRQ` follows one cycle later.
- Reset values: `RES_VALID`=0, `FP_RESULT`=0, `RES_EXCE`=`_NO_EXCE`, `STATUS`=0, `IRQ`=0, `EXCE_CNT`=0, `LOG_VALID`=0, `LOG_DATA`=0, `LOG_OVF`=0.
- Reset mid-transfer: any held result is discarded.

## Configuration
- `FPU_EXCE_LOG_EN` defined: a `LOG_DEPTH` FIFO captures every accepted excepting operation.
  - `LOG_DATA` shows the head entry; `LOG_POP && LOG_VALID` advances it.
  - Push while full drops the new entry and sets `LOG_OVF`.
  - Push and pop in the same cycle while full succeeds.
  - Pointers wrap modulo `LOG_DEPTH`.
- Undefined: the ports remain; `LOG_VALID`, `LOG_DATA`, `LOG_OVF` are tied 0 and `LOG_POP` is ignored.

## Structure
- `FPU_PACK.v` holds all shared constants: operation codes, `_NO_EXCE`/`_qNAN_EXCE`/`_INF_EXCE`/`_ZERO_DIV_EXCE`, `_PLUS_INF` (8'h78), `_MINUS_INF` (8'hF8), and new `_QNAN` (8'h7F) plus the `STATUS` bit indices.
- The existing zero checker is reused for the 0/0 test.
- One sub-module: `fpu_exce_log_fifo` (parameterised sync FIFO), instantiated only under `FPU_EXCE_LOG_EN`.

## Test plan
- **Clean pass-through:** `ARITH_RESULT`=8'h3C, no exception, `RES_READY`=1 → `FP_RESULT`=8'h3C one cycle later; `STATUS`=0, `EXCE_CNT`=0.
- **Divide by zero:** `_DIVISION`, A=8'hB8, B=8'h00, `_ZERO_DIV_EXCE` → `FP_RESULT`=8'hF8, DZ set. Then A=8'h00, B=8'h80 → 8'h7F, INV set. With `IRQ_MASK`=3'b100, `IRQ` rises 2 cycles after the first accept.
- **Backpressure:** `RES_READY`=0 for 3 cycles with `IN_VALID`=1 → `IN_READY`=0 and the output is held. Release → the held result transfers and the next operation is accepted the same cycle.
- **Saturation and clear:** 300 qNaN operations → `EXCE_CNT`=8'hFF. `FLAG_CLR` coincident with a new exception → `EXCE_CNT`=1 and NV=1.
- **Log (with `FPU_EXCE_LOG_EN`, `LOG_DEPTH`=4):** 5 excepting operations, no pop → 4 entries, `LOG_OVF`=1, first entry {`_MULTIPLICATION`, `_INF_EXCE`, 8'h00, 8'h78}. Push and pop while full → count stays 4.
- **Reset mid-transfer:** assert `RST_N`=0 while `RES_VALID`=1 → all outputs at reset values immediately, with no clock edge required.

Source files
------------

// File: rtl/fpu_exce_resolver_pkg.sv
// Shared constants, log payload type and zero checker for the FPU exception back-end.
package fpu_exce_resolver_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned EXCE_W = 3;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned FLAG_W = 3;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned LOG_W  = OP_W + EXCE_W + 2 * DATA_W;

    localparam logic [OP_W-1:0] _ADDITION       = 2'd0;
    localparam logic [OP_W-1:0] _SUBTRACTION    = 2'd1;
    localparam logic [OP_W-1:0] _MULTIPLICATION = 2'd2;
    localparam logic [OP_W-1:0] _DIVISION       = 2'd3;

    localparam logic [EXCE_W-1:0] _NO_EXCE       = 3'd0;
    localparam logic [EXCE_W-1:0] _qNAN_EXCE     = 3'd1;
    localparam logic [EXCE_W-1:0] _INF_EXCE      = 3'd2;
    localparam logic [EXCE_W-1:0] _ZERO_DIV_EXCE = 3'd3;

    localparam logic [DATA_W-1:0] _PLUS_INF  = 8'h78;
    localparam logic [DATA_W-1:0] _MINUS_INF = 8'hF8;
    localparam logic [DATA_W-1:0] _QNAN      = 8'h7F;

    localparam int unsigned STATUS_NV  = 0;
    localparam int unsigned STATUS_INV = 1;
    localparam int unsigned STATUS_DZ  = 2;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [EXCE_W-1:0] exce;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } log_entry_t;

    // Zero checker: +0 or -0 regardless of sign.
    function automatic logic is_zero(input logic [DATA_W-1:0] x);
        return x[DATA_W-2:0] == '0;
    endfunction

endpackage

// File: rtl/fpu_exce_log_fifo.sv
// Parameterised synchronous FIFO holding excepting operations; drops pushes when full and flags overflow.
module fpu_exce_log_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 21
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    input  logic             clr,
    output logic             valid,
    output logic [WIDTH-1:0] dout,
    output logic             ovf
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             full_c;
    logic             pop_c;
    logic             push_c;

    assign full_c = (count == (AW+1)'(DEPTH));
    assign pop_c  = pop && valid;
    // A pop in the same cycle frees the slot the incoming entry needs.
    assign push_c = push && (!full_c || pop_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_c) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(push_c) - (AW+1)'(pop_c);
            if (push && !push_c) begin
                ovf <= 1'b1;
            end else if (clr) begin
                ovf <= 1'b0;
            end
        end
    end

    assign valid = (count != '0);
    assign dout  = mem[rd_ptr];

endmodule

// File: rtl/fpu_exce_resolver.sv
// FPU exception back-end: substitutes special results, tracks sticky flags, counter and IRQ.
// Optional exception log enabled by defining FPU_EXCE_LOG_EN.
module fpu_exce_resolver
    import fpu_exce_resolver_pkg::*;
#(
    parameter int unsigned LOG_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [1:0]  FP_OPERATION,
    input  logic [7:0]  OP_A,
    input  logic [7:0]  OP_B,
    input  logic [7:0]  ARITH_RESULT,
    input  logic        OP_IS_EXCEPTION,
    input  logic [2:0]  FP_EXCE,
    output logic        RES_VALID,
    input  logic        RES_READY,
    output logic [7:0]  FP_RESULT,
    output logic [2:0]  RES_EXCE,
    output logic [2:0]  STATUS,
    input  logic        FLAG_CLR,
    input  logic [2:0]  IRQ_MASK,
    output logic        IRQ,
    output logic [7:0]  EXCE_CNT,
    output logic        LOG_VALID,
    output logic [20:0] LOG_DATA,
    input  logic        LOG_POP,
    output logic        LOG_OVF
);

    logic                accept_c;
    logic                exc_accept_c;
    logic [DATA_W-1:0]   res_c;
    logic [EXCE_W-1:0]   exce_c;
    logic [FLAG_W-1:0]   set_c;
    logic [FLAG_W-1:0]   status_nxt_c;
    logic [CNT_W-1:0]    cnt_base_c;
    logic [CNT_W-1:0]    cnt_nxt_c;

    assign IN_READY     = !RES_VALID || RES_READY;
    assign accept_c     = IN_VALID && IN_READY;
    assign exc_accept_c = accept_c && OP_IS_EXCEPTION;

    // Result substitution and flag-set decode.
    always_comb begin
        res_c  = ARITH_RESULT;
        exce_c = _NO_EXCE;
        set_c  = '0;
        if (OP_IS_EXCEPTION) begin
            exce_c = FP_EXCE;
            case (FP_EXCE)
                _qNAN_EXCE: begin
                    res_c            = _QNAN;
                    set_c[STATUS_NV] = 1'b1;
                end
                _INF_EXCE: begin
                    res_c             = _QNAN;
                    set_c[STATUS_INV] = 1'b1;
                end
                _ZERO_DIV_EXCE: begin
                    set_c[STATUS_DZ] = 1'b1;
                    if (is_zero(OP_A)) begin
                        res_c             = _QNAN;
                        set_c[STATUS_INV] = 1'b1;
                    end else begin
                        res_c = {OP_A[7] ^ OP_B[7], _PLUS_INF[6:0]};
                    end
                end
                default: begin
                    res_c             = _QNAN;
                    set_c[STATUS_INV] = 1'b1;
                end
            endcase
        end
    end

    // A clear coincident with a new exception still records that exception.
    always_comb begin
        status_nxt_c = (FLAG_CLR ? '0 : STATUS) | (exc_accept_c ? set_c : '0);
        cnt_base_c   = FLAG_CLR ? '0 : EXCE_CNT;
        cnt_nxt_c    = cnt_base_c;
        if (exc_accept_c && (cnt_base_c != '1)) begin
            cnt_nxt_c = cnt_base_c + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            RES_VALID <= 1'b0;
            FP_RESULT <= '0;
            RES_EXCE  <= _NO_EXCE;
            STATUS    <= '0;
            EXCE_CNT  <= '0;
            IRQ       <= 1'b0;
        end else begin
            if (accept_c) begin
                RES_VALID <= 1'b1;
                FP_RESULT <= res_c;
                RES_EXCE  <= exce_c;
            end else if (RES_READY) begin
                RES_VALID <= 1'b0;
            end
            STATUS   <= status_nxt_c;
            EXCE_CNT <= cnt_nxt_c;
            IRQ      <= |(STATUS & IRQ_MASK);
        end
    end

`ifdef FPU_EXCE_LOG_EN
    log_entry_t log_in_c;

    assign log_in_c = '{op: FP_OPERATION, exce: FP_EXCE, a: OP_A, b: OP_B};

    fpu_exce_log_fifo #(
        .DEPTH (LOG_DEPTH),
        .WIDTH (LOG_W)
    ) u_log (
        .clk   (CLK),
        .rst_n (RST_N),
        .push  (exc_accept_c),
        .din   (log_in_c),
        .pop   (LOG_POP),
        .clr   (FLAG_CLR),
        .valid (LOG_VALID),
        .dout  (LOG_DATA),
        .ovf   (LOG_OVF)
    );
`else
    logic unused_log;

    assign unused_log = ^{LOG_POP, FP_OPERATION, OP_B[6:0], 1'(LOG_DEPTH)};
    assign LOG_VALID  = 1'b0;
    assign LOG_DATA   = '0;
    assign LOG_OVF    = 1'b0;
`endif

endmodule
